// File: rtl/jpeg_idct_serialise_if.sv
// Stream bundle for the IDCT column-pass reassembly stage.
// inport_*  : 4-sample column beats from the IDCT datapath (valid/accept handshake).
// outport_* : raster-ordered serial samples to the next stage (valid/ready handshake).
// Suffixes _i/_o give the direction as seen by the serialiser (slave modport).
interface jpeg_idct_serialise_if #(
    parameter int unsigned DATA_W = 16
);
    logic              inport_valid_i;
    logic [DATA_W-1:0] inport_data0_i;
    logic [DATA_W-1:0] inport_data1_i;
    logic [DATA_W-1:0] inport_data2_i;
    logic [DATA_W-1:0] inport_data3_i;
    logic [3:0]        inport_idx_i;
    logic              inport_accept_o;
    logic              outport_valid_o;
    logic [DATA_W-1:0] outport_data_o;
    logic [5:0]        outport_idx_o;
    logic              outport_last_o;
    logic              outport_ready_i;

    // Serialiser side
    modport slave (
        input  inport_valid_i, inport_data0_i, inport_data1_i, inport_data2_i,
               inport_data3_i, inport_idx_i, outport_ready_i,
        output inport_accept_o, outport_valid_o, outport_data_o, outport_idx_o,
               outport_last_o
    );

    // Producer/consumer side
    modport master (
        output inport_valid_i, inport_data0_i, inport_data1_i, inport_data2_i,
               inport_data3_i, inport_idx_i, outport_ready_i,
        input  inport_accept_o, outport_valid_o, outport_data_o, outport_idx_o,
               outport_last_o
    );
endinterface

// File: rtl/jpeg_idct_serialise.sv
// Ping-pong reassembly buffer for the IDCT column pass.
// Accepts 16 beats per 8x8 block, each carrying 4 rows of one column
// (beat b -> rows 4*b[3]+0..3, column b[2:0]), and drains the block as a
// raster-ordered serial stream idx 0..63 while the other bank fills.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   img_start_i  synchronous flush of all buffered blocks
//   bus          stream bundle (slave modport): inport beats in, outport samples out
module jpeg_idct_serialise #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  img_start_i,
    jpeg_idct_serialise_if.slave  bus
);
    localparam int unsigned DEPTH = 64;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned LANES = 4;

    logic [DATA_W-1:0] mem_q [2][DEPTH];

    logic [1:0]       full_q,    full_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] rd_idx_q,  rd_idx_d;

    logic              in_fire;
    logic              out_fire;
    logic              wr_en;
    logic [DATA_W-1:0] lane [LANES];

    // Handshake and read-side outputs are pure functions of state
    assign bus.inport_accept_o = ~full_q[wr_bank_q];
    assign bus.outport_valid_o = full_q[rd_bank_q];
    assign bus.outport_data_o  = mem_q[rd_bank_q][rd_idx_q];
    assign bus.outport_idx_o   = rd_idx_q;
    assign bus.outport_last_o  = full_q[rd_bank_q] & (rd_idx_q == IDX_W'(DEPTH - 1));

    assign in_fire  = bus.inport_valid_i & bus.inport_accept_o;
    assign out_fire = bus.outport_valid_o & bus.outport_ready_i;
    // A flush drops any beat presented in the same cycle
    assign wr_en    = in_fire & ~img_start_i;

    assign lane[0] = bus.inport_data0_i;
    assign lane[1] = bus.inport_data1_i;
    assign lane[2] = bus.inport_data2_i;
    assign lane[3] = bus.inport_data3_i;

    // Sample storage; raster address of lane k is {idx[3], k, idx[2:0]}
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < int'(LANES); k++) begin
                mem_q[wr_bank_q][{bus.inport_idx_i[3], 2'(k), bus.inport_idx_i[2:0]}] <= lane[k];
            end
        end
    end

    // Bank bookkeeping; fill and drain always target different banks
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        if (img_start_i) begin
            full_d    = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            rd_idx_d  = '0;
        end else begin
            if (in_fire && (bus.inport_idx_i == 4'd15)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
            if (out_fire) begin
                rd_idx_d = rd_idx_q + IDX_W'(1);
                if (rd_idx_q == IDX_W'(DEPTH - 1)) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
        end
    end
endmodule
